elem_sinv_seq: RTL and testbench

//  Sequencer sharing one scalar sinv unit across every element of a ROWS x COLS matrix.
//  - Replaces ROWS*COLS parallel sinv instances where area matters.
//  - Captures the input matrix on start and issues elements in row-major order (row 1 col 1 first).
//  - Drives the external unit over a req/ack handshake and writes each result into the output matrix.
//  - Latency-agnostic: works with a combinational or a multi-cycle iterative sinv.

---
 rtl/elem_sinv_seq.sv | 120 ++++++++++++
 tb/tb_elem_sinv_seq.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/elem_sinv_seq.sv
// Walks a ROWS x COLS matrix in row-major order through one shared scalar sinv unit.
// The operand matrix is captured on start, and each unit result is written into the registered result matrix.
module elem_sinv_seq #(
  parameter int ROWS  = 1,
  parameter int COLS  = 1,
  parameter int WIDTH = 16
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic                               start_i,
  input  logic [ROWS:1][COLS:1][WIDTH-1:0]   a_i,
  output logic                               busy_o,
  output logic                               done_o,
  output logic [ROWS:1][COLS:1][WIDTH-1:0]   f_o,
  output logic [WIDTH-1:0]                   u_a_o,
  output logic                               u_req_o,
  input  logic                               u_ack_i,
  input  logic [WIDTH-1:0]                   u_f_i,
  output logic [1:0]                         state_o
);

  localparam int RW = $clog2(ROWS + 1);
  localparam int CW = $clog2(COLS + 1);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS);
  localparam logic [CW-1:0] COL_ONE  = CW'(1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e                              state_q;
  logic [ROWS:1][COLS:1][WIDTH-1:0]    areg_q;
  logic [ROWS:1][COLS:1][WIDTH-1:0]    f_q;
  logic [RW-1:0]                       row_q, row_d;
  logic [CW-1:0]                       col_q, col_d;
  logic                                busy_q, done_q, req_q;
  logic                                last_elem;

  // Unit interface: u_req/u_ack is a valid/ready pair. While u_req is high, u_a holds until an ack.
  // An ack transfers u_f in that same cycle. u_ack is ignored whenever u_req is low.
  assign last_elem = (row_q == ROW_LAST) && (col_q == COL_LAST);

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (col_q == COL_LAST) begin
      col_d = COL_ONE;
      row_d = row_q + ROW_ONE;
    end else begin
      col_d = col_q + COL_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      areg_q  <= '0;
      f_q     <= '0;
      row_q   <= ROW_ONE;
      col_q   <= COL_ONE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            areg_q  <= a_i;
            f_q     <= '0;
            row_q   <= ROW_ONE;
            col_q   <= COL_ONE;
            busy_q  <= 1'b1;
            req_q   <= 1'b1;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (u_ack_i) begin
            f_q[row_q][col_q] <= u_f_i;
            if (last_elem) begin
              busy_q  <= 1'b0;
              req_q   <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              row_q <= row_d;
              col_q <= col_d;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          row_q   <= ROW_ONE;
          col_q   <= COL_ONE;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          req_q   <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // The operand is driven only while a request is outstanding, so the bus reads zero when idle.
  assign u_a_o   = req_q ? areg_q[row_q][col_q] : '0;
  assign u_req_o = req_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign f_o     = f_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_elem_sinv_seq.sv
// Directed bench for elem_sinv_seq using 2x3, 2x2, 3x3 and 1x1 instances.
// Elements are Q8.8 and the unit model computes 1/x.
module tb_elem_sinv_seq;

  localparam int W = 16;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] f;
  } vec_t;

  logic clk, rst;
  int   nchk, nerr;

  // 2x3 instance, ack driven directly by the bench
  logic s23, busy23, done23, req23, ack23;
  logic [2:1][3:1][W-1:0] a23, f23, exp23;
  logic [W-1:0] ua23, uf23;
  logic [1:0]   st23;
  // 2x2 instance, latency-programmable unit model
  logic s22, busy22, done22, req22, ack22;
  logic [2:1][2:1][W-1:0] a22, f22, exp22;
  logic [W-1:0] ua22, uf22;
  logic [1:0]   st22;
  int           lat22, cnt22, wr22, dn22;
  // 3x3 instance, ack tied high
  logic s33, busy33, done33, req33;
  logic [3:1][3:1][W-1:0] a33, f33, exp33;
  logic [W-1:0] ua33, uf33;
  logic [1:0]   st33;
  int           dn33;
  // 1x1 instance, ack tied high
  logic s11, busy11, done11, req11;
  logic [1:1][1:1][W-1:0] a11, f11;
  logic [W-1:0] ua11, uf11;
  logic [1:0]   st11;

  logic [W-1:0] exp_q[$];

  elem_sinv_seq #(.ROWS(2), .COLS(3), .WIDTH(W)) u_d23 (
    .clk_i(clk), .reset_i(rst), .start_i(s23), .a_i(a23), .busy_o(busy23), .done_o(done23),
    .f_o(f23), .u_a_o(ua23), .u_req_o(req23), .u_ack_i(ack23), .u_f_i(uf23), .state_o(st23));
  elem_sinv_seq #(.ROWS(2), .COLS(2), .WIDTH(W)) u_d22 (
    .clk_i(clk), .reset_i(rst), .start_i(s22), .a_i(a22), .busy_o(busy22), .done_o(done22),
    .f_o(f22), .u_a_o(ua22), .u_req_o(req22), .u_ack_i(ack22), .u_f_i(uf22), .state_o(st22));
  elem_sinv_seq #(.ROWS(3), .COLS(3), .WIDTH(W)) u_d33 (
    .clk_i(clk), .reset_i(rst), .start_i(s33), .a_i(a33), .busy_o(busy33), .done_o(done33),
    .f_o(f33), .u_a_o(ua33), .u_req_o(req33), .u_ack_i(1'b1), .u_f_i(uf33), .state_o(st33));
  elem_sinv_seq #(.ROWS(1), .COLS(1), .WIDTH(W)) u_d11 (
    .clk_i(clk), .reset_i(rst), .start_i(s11), .a_i(a11), .busy_o(busy11), .done_o(done11),
    .f_o(f11), .u_a_o(ua11), .u_req_o(req11), .u_ack_i(1'b1), .u_f_i(uf11), .state_o(st11));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] sinv(input logic [W-1:0] x);
    int xs, q;
    if (x == '0) return 16'h7FFF;
    xs = int'($signed(x));
    q  = 65536 / xs;
    return q[W-1:0];
  endfunction

  assign uf23  = sinv(ua23);
  assign uf22  = sinv(ua22);
  assign uf33  = sinv(ua33);
  assign uf11  = sinv(ua11);
  assign ack22 = req22 && (cnt22 == lat22);

  always @(posedge clk) begin
    if (rst || !req22 || ack22) cnt22 <= 0;
    else cnt22 <= cnt22 + 1;
  end

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard: operand order seen by the unit on the 2x3 instance
  always @(posedge clk) begin
    if (!rst && req23 && ack23) begin
      if (exp_q.size() == 0) chk("sb_unexpected_issue", 192'(ua23), 192'hDEAD);
      else chk("sb_issue_order", 192'(ua23), 192'(exp_q.pop_front()));
    end
    if (!rst && req22 && ack22) wr22 <= wr22 + 1;
    if (!rst && done22) dn22 <= dn22 + 1;
    if (!rst && done33) dn33 <= dn33 + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t tbl1[6];
  vec_t tbl2[4];
  vec_t tbl3[4];

  initial begin
    nchk = 0; nerr = 0;
    tbl1[0] = '{16'h0100, 16'h0100}; tbl1[1] = '{16'h0200, 16'h0080};
    tbl1[2] = '{16'h0400, 16'h0040}; tbl1[3] = '{16'hFF00, 16'hFF00};
    tbl1[4] = '{16'hFE00, 16'hFF80}; tbl1[5] = '{16'hFC00, 16'hFFC0};
    tbl2[0] = '{16'h0080, 16'h0200}; tbl2[1] = '{16'hFF80, 16'hFE00};
    tbl2[2] = '{16'h0200, 16'h0080}; tbl2[3] = '{16'h0040, 16'h0400};
    tbl3[0] = '{16'h0100, 16'h0100}; tbl3[1] = '{16'h0800, 16'h0020};
    tbl3[2] = '{16'hFF80, 16'hFE00}; tbl3[3] = '{16'hFFC0, 16'hFC00};

    rst = 1'b1; s23 = 0; s22 = 0; s33 = 0; s11 = 0; ack23 = 1'b1; lat22 = 0;
    a23 = '0; a22 = '0; a33 = '0; a11 = '0; wr22 = 0; dn22 = 0; dn33 = 0;
    repeat (2) tick();
    chk("rst_busy", 192'({busy23, busy22, busy33, busy11}), 192'h0);
    chk("rst_done", 192'({done23, done22, done33, done11}), 192'h0);
    chk("rst_req", 192'({req23, req22, req33, req11}), 192'h0);
    chk("rst_ua", 192'({ua23, ua22, ua33, ua11}), 192'h0);
    chk("rst_f23", 192'(f23), 192'h0);
    chk("rst_state", 192'({st23, st22, st33, st11}), 192'h0);
    rst = 1'b0;
    tick();

    // 1: 2x3 with ack tied high, so done lands in cycle 7
    for (int i = 0; i < 6; i++) begin
      a23[i/3+1][i%3+1] = tbl1[i].a;
      exp23[i/3+1][i%3+1] = tbl1[i].f;
      exp_q.push_back(tbl1[i].a);
    end
    s23 = 1'b1;
    tick();
    s23 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("t1_req", 192'({req23, busy23, done23}), 192'b110);
      chk("t1_ua", 192'(ua23), 192'(tbl1[i].a));
      tick();
    end
    chk("t1_done", 192'({done23, busy23, req23}), 192'b100);
    chk("t1_f", 192'(f23), 192'(exp23));
    tick();
    chk("t1_idle", 192'({done23, st23}), 192'h0);

    // 2: 2x2 with a 3-cycle ack latency, so done lands in cycle 17
    for (int i = 0; i < 4; i++) begin
      a22[i/2+1][i%2+1] = tbl2[i].a;
      exp22[i/2+1][i%2+1] = tbl2[i].f;
    end
    lat22 = 3; wr22 = 0;
    s22 = 1'b1;
    tick();
    s22 = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      chk("t2_req", 192'({req22, done22}), 192'b10);
      chk("t2_ua_stable", 192'(ua22), 192'(tbl2[(c-1)/4].a));
      tick();
    end
    chk("t2_done", 192'({done22, req22}), 192'b10);
    chk("t2_f", 192'(f22), 192'(exp22));
    chk("t2_writes", 192'(wr22), 192'd4);
    tick();
    chk("t2_done_pulse", 192'(done22), 192'd0);

    // 3: repeated start pulses and a change on a during the operation are both ignored
    for (int i = 0; i < 4; i++) begin
      a22[i/2+1][i%2+1] = tbl3[i].a;
      exp22[i/2+1][i%2+1] = tbl3[i].f;
    end
    lat22 = 0; dn22 = 0;
    s22 = 1'b1;
    tick();
    s22 = 1'b0;
    tick();
    s22 = 1'b1; a22 = {4{16'h0200}};
    chk("t3_ua_c2", 192'(ua22), 192'(tbl3[1].a));
    tick();
    s22 = 1'b0;
    tick();
    s22 = 1'b1;
    tick();
    s22 = 1'b0;
    chk("t3_done", 192'(done22), 192'd1);
    chk("t3_f", 192'(f22), 192'(exp22));
    repeat (2) tick();
    chk("t3_single_done", 192'(dn22), 192'd1);
    chk("t3_idle", 192'({st22, busy22, req22}), 192'h0);

    // 4: 3x3 aborted by a reset in cycle 5, then restarted from scratch
    for (int i = 0; i < 9; i++) begin
      a33[i/3+1][i%3+1] = 16'((i + 1) * 64) ^ ((i % 2) == 1 ? 16'h8000 : 16'h0000);
      exp33[i/3+1][i%3+1] = sinv(a33[i/3+1][i%3+1]);
    end
    dn33 = 0;
    s33 = 1'b1;
    tick();
    s33 = 1'b0;
    repeat (4) tick();
    chk("t4_partial", 192'(f33[1][1]), 192'(exp33[1][1]));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t4_rst_ctl", 192'({busy33, req33, done33, st33}), 192'h0);
    chk("t4_rst_f", 192'(f33), 192'h0);
    repeat (3) tick();
    chk("t4_no_done", 192'(dn33), 192'd0);
    s33 = 1'b1;
    tick();
    s33 = 1'b0;
    for (int i = 0; i < 9; i++) begin
      chk("t4_ua", 192'(ua33), 192'(a33[i/3+1][i%3+1]));
      tick();
    end
    chk("t4_done", 192'(done33), 192'd1);
    chk("t4_f", 192'(f33), 192'(exp33));

    // 5: 1x1 operand 8.0 gives 0.125, with done in cycle 2 and IDLE again in cycle 3
    a11 = 16'h0800;
    s11 = 1'b1;
    tick();
    s11 = 1'b0;
    chk("t5_req", 192'({req11, ua11}), 192'({1'b1, 16'h0800}));
    tick();
    chk("t5_done", 192'({done11, f11}), 192'({1'b1, 16'h0020}));
    tick();
    chk("t5_idle", 192'({done11, st11}), 192'h0);

    // 6: start held high back to back while ack stays high outside ISSUE
    for (int i = 0; i < 6; i++) begin
      a23[i/3+1][i%3+1] = tbl1[i].a;
      exp_q.push_back(tbl1[i].a);
    end
    for (int i = 0; i < 6; i++) exp_q.push_back(16'h0200);
    s23 = 1'b1;
    tick();
    a23 = {6{16'h0200}};
    for (int i = 0; i < 6; i++) begin
      chk("t6_ua_op1", 192'(ua23), 192'(tbl1[i].a));
      tick();
    end
    chk("t6_done1", 192'(done23), 192'd1);
    chk("t6_f1", 192'(f23), 192'(exp23));
    tick();
    chk("t6_idle", 192'({st23, req23, done23}), 192'h0);
    chk("t6_f_hold", 192'(f23), 192'(exp23));
    tick();
    s23 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("t6_ua_op2", 192'({req23, ua23}), 192'({1'b1, 16'h0200}));
      tick();
    end
    chk("t6_done2", 192'(done23), 192'd1);
    chk("t6_f2", 192'(f23), 192'({6{16'h0080}}));
    tick();
    chk("t6_end_idle", 192'({st23, busy23}), 192'h0);
    chk("sb_drained", 192'(exp_q.size()), 192'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
